// File: rtl/isa_pkg.sv
// Shared ISA constants for the next-PC logic: datapath width, branch
// condition codes and ALU flag bit positions.
package isa_pkg;

    localparam int AW = 32;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_BZ   = 3'b001;
    localparam logic [2:0] COND_BNZ  = 3'b010;
    localparam logic [2:0] COND_BLTZ = 3'b011;
    localparam logic [2:0] COND_BGEZ = 3'b100;
    localparam logic [2:0] COND_BCY  = 3'b101;
    localparam logic [2:0] COND_BNCY = 3'b110;
    localparam logic [2:0] COND_RSVD = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps the 3-bit condition code and the ALU
// flags onto a single "condition satisfied" bit.
module branch_cond
    import isa_pkg::*;
(
    input  logic [2:0] conditional,
    input  logic [2:0] flags,
    output logic       cond_ok
);

    logic w_z;
    logic w_s;
    logic w_c;

    assign w_z = flags[FLAG_Z];
    assign w_s = flags[FLAG_S];
    assign w_c = flags[FLAG_C];

    // Sum-of-products decode rather than a case statement so that an unknown
    // condition code or flag shows up as X on cond_ok instead of being hidden
    // by a default branch. COND_NONE and COND_RSVD have no term and yield 0.
    assign cond_ok = ((conditional == COND_BZ  ) &  w_z)
                   | ((conditional == COND_BNZ ) & ~w_z)
                   | ((conditional == COND_BLTZ) &  w_s)
                   | ((conditional == COND_BGEZ) & ~w_s)
                   | ((conditional == COND_BCY ) &  w_c)
                   | ((conditional == COND_BNCY) & ~w_c);

endmodule

// File: rtl/jump_unit.sv
// Next-PC selection: chooses between the sequential PC and a jump/branch
// target, and keeps a registered copy of the result for the fetch stage.
module jump_unit
    import isa_pkg::*;
#(
    parameter int          AW     = isa_pkg::AW,
    parameter int unsigned PC_INC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] PCin,
    input  logic [AW-1:0] address,
    input  logic [AW-1:0] res,
    input  logic          AdSel,
    input  logic          unconditional,
    input  logic [2:0]    conditional,
    input  logic [2:0]    flags,
    output logic [AW-1:0] next_address,
    output logic          taken,
    output logic [AW-1:0] pc_q
);

    logic          w_cond_ok;
    logic          w_taken;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_seq_pc;
    logic [AW-1:0] r_pc_q;

    branch_cond u_branch_cond (
        .conditional (conditional),
        .flags       (flags),
        .cond_ok     (w_cond_ok)
    );

    // Ternaries keep X on a select visible in the result instead of
    // silently picking one side.
    assign w_target = AdSel ? res : address;

    // Wraps modulo 2^AW by construction; no carry out is kept.
    assign w_seq_pc = PCin + AW'(PC_INC);

    assign w_taken      = unconditional | w_cond_ok;
    assign taken        = w_taken;
    assign next_address = w_taken ? w_target : w_seq_pc;

    // pc_q register: clears asynchronously, loads next_address when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_q <= '0;
        end else if (en) begin
            r_pc_q <= next_address;
        end
    end

    assign pc_q = r_pc_q;

endmodule

// File: tb/tb_jump_unit.sv
// Directed bench for jump_unit: combinational next-PC selection, condition
// decode sweep, PC wrap, and the pc_q register with async reset.
module tb_jump_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] PCin;
    logic [31:0] address;
    logic [31:0] res;
    logic        AdSel;
    logic        unconditional;
    logic [2:0]  conditional;
    logic [2:0]  flags;
    logic [31:0] next_address;
    logic        taken;
    logic [31:0] pc_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] na;
        logic        tk;
        string       tag;
    } exp_t;

    exp_t sbq[$];

    jump_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .PCin          (PCin),
        .address       (address),
        .res           (res),
        .AdSel         (AdSel),
        .unconditional (unconditional),
        .conditional   (conditional),
        .flags         (flags),
        .next_address  (next_address),
        .taken         (taken),
        .pc_q          (pc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written straight from the condition table.
    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        case (c)
            3'b001:  return  f[0];
            3'b010:  return ~f[0];
            3'b011:  return  f[1];
            3'b100:  return ~f[1];
            3'b101:  return  f[2];
            3'b110:  return ~f[2];
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction's inputs, push the expected result, then pop and
    // compare once the combinational outputs have settled.
    task automatic apply(input logic [31:0] pc, input logic [31:0] ad,
                         input logic [31:0] rs, input logic sel,
                         input logic unc, input logic [2:0] cnd,
                         input logic [2:0] flg, input string tag);
        exp_t e;
        logic tk;
        PCin          = pc;
        address       = ad;
        res           = rs;
        AdSel         = sel;
        unconditional = unc;
        conditional   = cnd;
        flags         = flg;
        tk   = unc | ref_cond(cnd, flg);
        e.tk = tk;
        e.na = tk ? (sel ? rs : ad) : pc + 32'd1;
        e.tag = tag;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        total++;
        assert (next_address === e.na) else begin
            bad++;
            $error("FAIL %s next_address got=%h exp=%h", e.tag, next_address, e.na);
        end
        total++;
        assert (taken === e.tk) else begin
            bad++;
            $error("FAIL %s taken got=%b exp=%b", e.tag, taken, e.tk);
        end
    endtask

    task automatic check_pc(input logic [31:0] exp, input string tag);
        total++;
        assert (pc_q === exp) else begin
            bad++;
            $error("FAIL %s pc_q got=%h exp=%h", tag, pc_q, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b000, 3'b000, "reset_inputs");
        #3;
        check_pc(32'd0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential, unconditional, register target
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b000, 3'b000, "seq");
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b1, 3'b000, 3'b000, "jmp_addr");
        apply(32'd2, 32'd35, 32'd45, 1'b1, 1'b1, 3'b000, 3'b000, "jmp_res");

        // bz / bnz
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b001, 3'b001, "bz_z1");
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b001, 3'b000, "bz_z0");
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b010, 3'b001, "bnz_z1");
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b010, 3'b000, "bnz_z0");

        // Unconditional overrides a false / reserved condition
        apply(32'd7, 32'd100, 32'd200, 1'b1, 1'b1, 3'b111, 3'b111, "unc_over_rsvd");
        apply(32'd7, 32'd100, 32'd200, 1'b0, 1'b1, 3'b001, 3'b000, "unc_over_false");

        // Sweep remaining condition codes over every flag pattern
        for (int c = 3; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                apply($urandom_range(1000, 0), 32'h0000_1234, 32'h0000_ABCD,
                      1'($urandom_range(1, 0)), 1'b0, 3'(c), 3'(f),
                      $sformatf("sweep_c%0d_f%0d", c, f));
            end
        end

        // PC wrap
        apply(32'hFFFF_FFFF, 32'd35, 32'd45, 1'b0, 1'b0, 3'b000, 3'b000, "wrap");

        // pc_q register behaviour
        @(negedge clk);
        en = 1'b1;
        apply(32'd10, 32'd35, 32'd45, 1'b0, 1'b0, 3'b000, 3'b000, "pre_load");
        @(posedge clk);
        #1;
        check_pc(32'd11, "load_11");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_pc(32'd0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'd2, 32'd35, 32'd45, 1'b0, 1'b0, 3'b000, 3'b000, "post_rst");
        check_pc(32'd0, "no_edge_yet");
        @(posedge clk);
        #1;
        check_pc(32'd3, "load_3");
        @(negedge clk);
        en = 1'b0;
        apply(32'd50, 32'd35, 32'd45, 1'b0, 1'b1, 3'b000, 3'b000, "hold_inputs");
        @(posedge clk);
        #1;
        check_pc(32'd3, "hold_1");
        @(posedge clk);
        #1;
        check_pc(32'd3, "hold_2");
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check_pc(32'd35, "reload_jump");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
